// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes, default widths and
// the control-flag bundle (with its bubble value) carried by ID/EX.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic alu_src;
  } ex_flags_t;

  // A bubble carries no valid work and no side effects downstream.
  localparam ex_flags_t FLAGS_BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding for the EX stage: picks the youngest in-flight
// producer of each source register, EX/MEM ahead of MEM/WB. Register 0
// is never forwarded because it is hard-wired to zero.
module fwd_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [REG_AW-1:0] exmem_rd_addr,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_AW-1:0] memwb_rd_addr,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] rs_fwd,
  output logic [DATA_W-1:0] rt_fwd
);

  logic exmem_live;
  logic memwb_live;

  assign exmem_live = exmem_reg_write && (exmem_rd_addr != '0);
  assign memwb_live = memwb_reg_write && (memwb_rd_addr != '0);

  // Select each operand from the nearest producer, else the register read.
  always_comb begin
    rs_fwd = rs_data;
    rt_fwd = rt_data;
    if (exmem_live && (exmem_rd_addr == rs_addr)) begin
      rs_fwd = exmem_result;
    end else if (memwb_live && (memwb_rd_addr == rs_addr)) begin
      rs_fwd = memwb_result;
    end
    if (exmem_live && (exmem_rd_addr == rt_addr)) begin
      rt_fwd = exmem_result;
    end else if (memwb_live && (memwb_rd_addr == rt_addr)) begin
      rt_fwd = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with hazard stall and stall
// counter. Define ID_EX_FWD_EN to enable operand forwarding (only
// load-use hazards stall); without it, any RAW dependence on an
// in-flight producer stalls until that producer has retired.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_alu_src_i,
  input  logic [CTRL_W-1:0] id_alu_ctrl_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] exmem_rd_addr_i,
  input  logic              exmem_reg_write_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic [REG_AW-1:0] memwb_rd_addr_i,
  input  logic              memwb_reg_write_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  ex_flags_t         ex_flags;
  logic [REG_AW-1:0] ex_rs_addr;
  logic [REG_AW-1:0] ex_rt_addr;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [CTRL_W-1:0] ex_alu_ctrl;
  logic [REG_AW-1:0] ex_rd_addr;

  logic              hazard;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // True when a live producer writes a register the ID instruction reads.
  function automatic logic id_reads(input logic [REG_AW-1:0] rd,
                                    input logic              we,
                                    input logic [REG_AW-1:0] rs,
                                    input logic [REG_AW-1:0] rt);
    return we && (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

`ifdef ID_EX_FWD_EN

  fwd_unit #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd (
    .rs_addr        (ex_rs_addr),
    .rt_addr        (ex_rt_addr),
    .rs_data        (ex_rs_data),
    .rt_data        (ex_rt_data),
    .exmem_rd_addr  (exmem_rd_addr_i),
    .exmem_reg_write(exmem_reg_write_i),
    .exmem_result   (exmem_result_i),
    .memwb_rd_addr  (memwb_rd_addr_i),
    .memwb_reg_write(memwb_reg_write_i),
    .memwb_result   (memwb_result_i),
    .rs_fwd         (rs_val),
    .rt_fwd         (rt_val)
  );

  // Only a load in EX cannot be forwarded in time; rt is always compared.
  always_comb begin
    hazard = id_valid_i && ex_flags.valid &&
             id_reads(ex_rd_addr, ex_flags.mem_read, id_rs_addr_i, id_rt_addr_i);
  end

`else

  logic unused_nofwd;
  assign unused_nofwd = ^{exmem_result_i, memwb_result_i, ex_rs_addr, ex_rt_addr};

  assign rs_val = ex_rs_data;
  assign rt_val = ex_rt_data;

  // Without forwarding, wait until no in-flight producer targets a source.
  always_comb begin
    hazard = id_valid_i &&
             (id_reads(ex_rd_addr, ex_flags.valid && (ex_flags.reg_write || ex_flags.mem_read),
                       id_rs_addr_i, id_rt_addr_i) ||
              id_reads(exmem_rd_addr_i, exmem_reg_write_i, id_rs_addr_i, id_rt_addr_i) ||
              id_reads(memwb_rd_addr_i, memwb_reg_write_i, id_rs_addr_i, id_rt_addr_i));
  end

`endif

  // A taken branch discards the ID instruction, so it never needs to stall.
  assign stall_o = hazard && !flush_i;

  // Pipeline register: reset, then bubble on flush/stall, else capture ID.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_flags    <= FLAGS_BUBBLE;
      ex_rs_addr  <= '0;
      ex_rt_addr  <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_alu_ctrl <= '0;
      ex_rd_addr  <= '0;
    end else if (flush_i || stall_o) begin
      ex_flags    <= FLAGS_BUBBLE;
      ex_rs_addr  <= '0;
      ex_rt_addr  <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_alu_ctrl <= '0;
      ex_rd_addr  <= '0;
    end else begin
      ex_flags.valid     <= id_valid_i;
      ex_flags.reg_write <= id_reg_write_i;
      ex_flags.mem_read  <= id_mem_read_i;
      ex_flags.alu_src   <= id_alu_src_i;
      ex_rs_addr         <= id_rs_addr_i;
      ex_rt_addr         <= id_rt_addr_i;
      ex_rs_data         <= id_rs_data_i;
      ex_rt_data         <= id_rt_data_i;
      ex_imm             <= id_imm_i;
      ex_alu_ctrl        <= id_alu_ctrl_i;
      ex_rd_addr         <= id_rd_addr_i;
    end
  end

  // Count stall cycles, holding at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  assign ex_valid_o      = ex_flags.valid;
  assign ex_reg_write_o  = ex_flags.reg_write;
  assign ex_mem_read_o   = ex_flags.mem_read;
  assign alu_ctrl_o      = ex_alu_ctrl;
  assign ex_rd_addr_o    = ex_rd_addr;
  assign src1_o          = rs_val;
  assign src2_o          = ex_flags.alu_src ? ex_imm : rt_val;
  assign ex_store_data_o = rt_val;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. Expected values are
// hand-derived; the ID_EX_FWD_EN macro selects the matching expectations.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs_addr_i;
  logic [4:0]  id_rt_addr_i;
  logic [31:0] id_rs_data_i;
  logic [31:0] id_rt_data_i;
  logic [31:0] id_imm_i;
  logic        id_alu_src_i;
  logic [3:0]  id_alu_ctrl_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_reg_write_i;
  logic        id_mem_read_i;
  logic        flush_i;
  logic [4:0]  exmem_rd_addr_i;
  logic        exmem_reg_write_i;
  logic [31:0] exmem_result_i;
  logic [4:0]  memwb_rd_addr_i;
  logic        memwb_reg_write_i;
  logic [31:0] memwb_result_i;
  logic        stall_o;
  logic        ex_valid_o;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_reg_write_o;
  logic        ex_mem_read_o;
  logic [31:0] ex_store_data_o;
  logic [15:0] stall_cnt_o;

  int errCount   = 0;
  int checkCount = 0;

  id_ex_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .id_valid_i       (id_valid_i),
    .id_rs_addr_i     (id_rs_addr_i),
    .id_rt_addr_i     (id_rt_addr_i),
    .id_rs_data_i     (id_rs_data_i),
    .id_rt_data_i     (id_rt_data_i),
    .id_imm_i         (id_imm_i),
    .id_alu_src_i     (id_alu_src_i),
    .id_alu_ctrl_i    (id_alu_ctrl_i),
    .id_rd_addr_i     (id_rd_addr_i),
    .id_reg_write_i   (id_reg_write_i),
    .id_mem_read_i    (id_mem_read_i),
    .flush_i          (flush_i),
    .exmem_rd_addr_i  (exmem_rd_addr_i),
    .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_result_i   (exmem_result_i),
    .memwb_rd_addr_i  (memwb_rd_addr_i),
    .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_result_i   (memwb_result_i),
    .stall_o          (stall_o),
    .ex_valid_o       (ex_valid_o),
    .src1_o           (src1_o),
    .src2_o           (src2_o),
    .alu_ctrl_o       (alu_ctrl_o),
    .ex_rd_addr_o     (ex_rd_addr_o),
    .ex_reg_write_o   (ex_reg_write_o),
    .ex_mem_read_o    (ex_mem_read_o),
    .ex_store_data_o  (ex_store_data_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                               input logic [4:0] rt, input logic [31:0] rtd,
                               input logic [31:0] imm, input logic asrc,
                               input logic [3:0] ctrl, input logic [4:0] rd,
                               input logic rw, input logic mr);
    id_valid_i     = v;
    id_rs_addr_i   = rs;
    id_rs_data_i   = rsd;
    id_rt_addr_i   = rt;
    id_rt_data_i   = rtd;
    id_imm_i       = imm;
    id_alu_src_i   = asrc;
    id_alu_ctrl_i  = ctrl;
    id_rd_addr_i   = rd;
    id_reg_write_i = rw;
    id_mem_read_i  = mr;
  endtask

  task automatic setProducers(input logic [4:0] erd, input logic ew, input logic [31:0] eres,
                              input logic [4:0] wrd, input logic ww, input logic [31:0] wres);
    exmem_rd_addr_i   = erd;
    exmem_reg_write_i = ew;
    exmem_result_i    = eres;
    memwb_rd_addr_i   = wrd;
    memwb_reg_write_i = ww;
    memwb_result_i    = wres;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i   = 1'b0;
    flush_i = 1'b0;
    setProducers(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'd5, 2, 32'd7, 0, 0, 4'd2, 5'd9, 1, 0);

    // Reset holds EX empty even with a valid ID instruction present
    tick();
    tick();
    checkOutput("rst_valid", {31'd0, ex_valid_o}, 0);
    checkOutput("rst_ctrl", {28'd0, alu_ctrl_o}, 0);
    checkOutput("rst_cnt", {16'd0, stall_cnt_o}, 0);
    checkOutput("rst_rw", {31'd0, ex_reg_write_o}, 0);
    checkOutput("rst_src1", src1_o, 0);

    // Plain passthrough
    rst_i = 1'b1;
    #1;
    checkOutput("pass_nostall", {31'd0, stall_o}, 0);
    tick();
    checkOutput("pass_valid", {31'd0, ex_valid_o}, 1);
    checkOutput("pass_src1", src1_o, 32'd5);
    checkOutput("pass_src2", src2_o, 32'd7);
    checkOutput("pass_ctrl", {28'd0, alu_ctrl_o}, 2);
    checkOutput("pass_rd", {27'd0, ex_rd_addr_o}, 9);

    // Immediate selects src2; store data still carries rt
    applyStimulus(1, 1, 32'd5, 2, 32'd7, 32'hFFFF_FFFC, 1, 4'd6, 5'd10, 1, 0);
    tick();
    checkOutput("imm_src2", src2_o, 32'hFFFF_FFFC);
    checkOutput("imm_store", ex_store_data_o, 32'd7);
    checkOutput("imm_ctrl", {28'd0, alu_ctrl_o}, 6);

    // Register 0 is never forwarded
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 0, 0);
    setProducers(0, 1, 32'hAB, 0, 0, 0);
    tick();
    checkOutput("zero_src1", src1_o, 0);
    checkOutput("zero_store", ex_store_data_o, 0);

    // Producer priority on rs=3 (registered data 0)
    setProducers(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 4'd2, 5'd0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 0, 0);
    setProducers(3, 1, 32'h10, 3, 1, 32'h20);
    #1;
`ifdef ID_EX_FWD_EN
    checkOutput("prio_exmem", src1_o, 32'h10);
`else
    checkOutput("nofwd_exmem", src1_o, 0);
`endif
    setProducers(3, 0, 32'h10, 3, 1, 32'h20);
    #1;
`ifdef ID_EX_FWD_EN
    checkOutput("prio_memwb", src1_o, 32'h20);
`else
    checkOutput("nofwd_memwb", src1_o, 0);
`endif
    setProducers(0, 0, 0, 0, 0, 0);
    tick();

    // Load-use: load rd=4 in EX, ID reads r4
    applyStimulus(1, 11, 0, 12, 0, 0, 0, 4'd2, 5'd4, 1, 1);
    tick();
    applyStimulus(1, 4, 32'h44, 13, 32'h55, 0, 0, 4'd2, 5'd14, 1, 0);
    #1;
    checkOutput("lu_stall", {31'd0, stall_o}, 1);
    tick();
    checkOutput("lu_bubble", {31'd0, ex_valid_o}, 0);
    checkOutput("lu_bubble_mr", {31'd0, ex_mem_read_o}, 0);
    checkOutput("lu_cnt", {16'd0, stall_cnt_o}, 1);
    checkOutput("lu_release", {31'd0, stall_o}, 0);
    tick();
    checkOutput("lu_capture", {31'd0, ex_valid_o}, 1);
    checkOutput("lu_rd", {27'd0, ex_rd_addr_o}, 14);
    checkOutput("lu_src1", src1_o, 32'h44);

    // Flush overrides a simultaneous load-use stall
    applyStimulus(1, 15, 0, 16, 0, 0, 0, 4'd2, 5'd5, 1, 1);
    tick();
    applyStimulus(1, 5, 32'h77, 17, 0, 0, 0, 4'd2, 5'd17, 1, 0);
    flush_i = 1'b1;
    #1;
    checkOutput("flush_nostall", {31'd0, stall_o}, 0);
    tick();
    flush_i = 1'b0;
    checkOutput("flush_bubble", {31'd0, ex_valid_o}, 0);
    checkOutput("flush_cnt", {16'd0, stall_cnt_o}, 1);

    // Producer only in EX/MEM, then moving to MEM/WB
    applyStimulus(1, 6, 32'h66, 0, 0, 0, 0, 4'd2, 5'd18, 1, 0);
    setProducers(6, 1, 32'h99, 0, 0, 0);
    #1;
`ifdef ID_EX_FWD_EN
    checkOutput("fwd_nostall", {31'd0, stall_o}, 0);
    setProducers(0, 0, 0, 0, 0, 0);
`else
    checkOutput("raw_stall1", {31'd0, stall_o}, 1);
    tick();
    setProducers(0, 0, 0, 6, 1, 32'h99);
    #1;
    checkOutput("raw_stall2", {31'd0, stall_o}, 1);
    checkOutput("raw_bubble", {31'd0, ex_valid_o}, 0);
    tick();
    setProducers(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("raw_release", {31'd0, stall_o}, 0);
    checkOutput("raw_cnt", {16'd0, stall_cnt_o}, 3);
    tick();
    checkOutput("raw_capture", {31'd0, ex_valid_o}, 1);
    checkOutput("raw_src1", src1_o, 32'h66);

    // Reset asserted while a stall is pending clears the counter
    setProducers(6, 1, 32'h99, 0, 0, 0);
`endif
    rst_i = 1'b0;
    tick();
    checkOutput("rst2_cnt", {16'd0, stall_cnt_o}, 0);
    checkOutput("rst2_valid", {31'd0, ex_valid_o}, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
